adding_machine_sequencer: RTL and testbench



---
 rtl/adding_machine_pkg.sv | 33 +++
 rtl/am_accumulator.sv | 53 +++++
 rtl/adding_machine_sequencer.sv | 114 +++++++++++
 tb/tb_adding_machine_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adding_machine_pkg.sv
// ---------------------------------------------------------------------------
// adding_machine_pkg
//
// Shared definitions for the adding machine sequencer and its accumulator.
//   - Bus widths for the ROM address, the data words and the word counter.
//   - Default base address and run length. The run length matches the ROM
//     depth, which decodes only addr[7:0].
//   - FSM state encoding.
//   - A helper that detects the last word a run may consume.
// ---------------------------------------------------------------------------
package adding_machine_pkg;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int COUNT_W = 9;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = '0;
  localparam int                DEFAULT_MAX_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DONE  = 2'b10
  } state_t;

  // True when the word being added now is the final word the run may
  // consume. That is the case when count will reach max_words after this add.
  function automatic logic is_last_word(input logic [COUNT_W-1:0] count,
                                        input int                 max_words);
    return count == COUNT_W'(max_words - 1);
  endfunction

endpackage

// File: rtl/am_accumulator.sv
// ---------------------------------------------------------------------------
// am_accumulator
//
// Holds the running 32-bit sum, the sticky carry-out flag and the count of
// words added.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   clear    in   zero sum, count and overflow (takes priority over add_en)
//   add_en   in   add data into the sum and bump the count
//   data     in   word to add
//   sum      out  accumulated sum, modulo 2^32
//   count    out  number of words added
//   overflow out  set once any add carries out of bit 31; cleared only by
//                 clear or reset
// ---------------------------------------------------------------------------
module am_accumulator
  import adding_machine_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               add_en,
  input  logic [DATA_W-1:0]  data,
  output logic [DATA_W-1:0]  sum,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);

  // The add is one bit wider than the sum so the carry out of bit 31 is
  // visible to the sticky overflow flag.
  logic [DATA_W:0] wide_sum;

  assign wide_sum = {1'b0, sum} + {1'b0, data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      sum      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (add_en) begin
      sum      <= wide_sum[DATA_W-1:0];
      overflow <= overflow | wide_sum[DATA_W];
      count    <= count + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/adding_machine_sequencer.sv
// ---------------------------------------------------------------------------
// adding_machine_sequencer
//
// Walks the word-addressed ROM starting at BASE_ADDR and sums the words it
// reads. A run stops at the first zero word, or after MAX_WORDS words.
//
// Parameters:
//   BASE_ADDR  first word address driven to the ROM
//   MAX_WORDS  maximum number of words consumed per run (ROM depth)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   start    in   begin a run; honoured only in IDLE or DONE
//   addr     out  registered word address to the ROM
//   data     in   ROM word for addr; valid before the next rising edge
//   sum      out  accumulated sum, modulo 2^32
//   count    out  number of non-zero words added
//   overflow out  sticky carry-out flag for the current run
//   busy     out  high while fetching
//   done     out  high once the run finishes; held until the next start
// ---------------------------------------------------------------------------
module adding_machine_sequencer
  import adding_machine_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int                MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  data,
  output logic [DATA_W-1:0]  sum,
  output logic [COUNT_W-1:0] count,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  state_t state;
  state_t next_state;

  logic word_nonzero;
  logic last_word;
  logic launch;
  logic add_en;

  assign word_nonzero = (data != '0);
  assign last_word    = is_last_word(count, MAX_WORDS);

  // A start is only honoured when no run is in progress. Start pulses that
  // arrive during FETCH are dropped.
  assign launch = start && ((state == IDLE) || (state == DONE));
  assign add_en = (state == FETCH) && word_nonzero;

  am_accumulator u_accumulator (
    .clk      (clk),
    .reset    (reset),
    .clear    (launch),
    .add_en   (add_en),
    .data     (data),
    .sum      (sum),
    .count    (count),
    .overflow (overflow)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A run ends on a zero word, or on the word that brings
  // the count up to MAX_WORDS. That final word is still added.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   if (!word_nonzero || last_word) next_state = DONE;
      DONE:    if (start) next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  // Output decode. busy and done depend only on the state register, so there
  // is no combinational path from data to any output.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      FETCH:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Address register. The address is not advanced past the last permitted
  // word, so a full-length run leaves addr at BASE_ADDR+MAX_WORDS-1 instead
  // of wrapping the ROM back to its first entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= BASE_ADDR;
    end else if (launch) begin
      addr <= BASE_ADDR;
    end else if (add_en && !last_word) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_adding_machine_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adding_machine_sequencer
//
// Models the ROM as a combinational array with a 2-unit delay. Each run's
// expected sum/count/overflow/final address and start-to-done latency are
// computed from the ROM contents when start is driven. They are pushed to a
// scoreboard and popped when done rises.
// ---------------------------------------------------------------------------
module tb_adding_machine_sequencer;
  import adding_machine_pkg::*;

  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [29:0] addr;
  logic [31:0] data;
  logic [31:0] sum;
  logic [8:0]  count;
  logic        overflow;
  logic        busy;
  logic        done;

  logic [31:0] rom [0:255];

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic [8:0]  count;
    logic        ovf;
    logic [29:0] addr;
  } result_t;

  typedef struct {
    result_t res;
    int      lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  assign #2 data = rom[addr[7:0]];

  adding_machine_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .addr     (addr),
    .data     (data),
    .sum      (sum),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
  endtask

  // Reference model: walk the ROM from address 0 until a zero word or 256
  // words. Latency counts clock edges from the start-sampling edge (edge 1)
  // up to and including the edge that raises done.
  function automatic exp_t model();
    exp_t        e;
    logic [32:0] acc;
    int          n;
    e.res = '0;
    n = 0;
    while (n < 256 && rom[n] != 32'h0) begin
      acc = {1'b0, e.res.sum} + {1'b0, rom[n]};
      e.res.sum = acc[31:0];
      e.res.ovf = e.res.ovf | acc[32];
      n++;
    end
    e.res.count = 9'(n);
    e.res.addr  = 30'((n == 256) ? 255 : n);
    e.lat       = (n == 256) ? n + 1 : n + 2;
    return e;
  endfunction

  // Push the expectation, then pulse start across one rising edge. This
  // returns at the falling edge just after the edge that sampled start.
  task automatic launch_run();
    sb_q.push_back(model());
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges until done is observed, bounded by LIMIT.
  task automatic wait_done(input int first, output int lat, output bit ok);
    lat = first;
    ok  = 1'b1;
    while (done !== 1'b1) begin
      if (lat >= LIMIT) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    result_t obs;
    clear_rom();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    obs = {sum, count, overflow, addr};
    checks++;
    if (obs !== result_t'(0)) $display("[TB] FAIL reset_regs: got %h, want 0", obs);
    else passed++;
    checks++;
    if ({busy, done} !== 2'b00) $display("[TB] FAIL reset_flags: busy/done got %b, want 00", {busy, done});
    else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t    e;
    result_t obs;
    int      lat;
    bit      ok;
    clear_rom();
    rom[0] = 32'd5;
    rom[1] = 32'd7;
    launch_run();
    checks++;
    if ({busy, done} !== 2'b10) $display("[TB] FAIL basic_busy: busy/done got %b, want 10", {busy, done});
    else passed++;
    wait_done(1, lat, ok);
    checks++;
    if (!ok) $display("[TB] FAIL basic_timeout: done not seen within %0d cycles", LIMIT);
    else passed++;
    e = sb_q.pop_front();
    obs = {sum, count, overflow, addr};
    checks++;
    if (obs !== e.res) $display("[TB] FAIL basic_result: got %h, want %h", obs, e.res);
    else passed++;
    checks++;
    if (lat !== e.lat) $display("[TB] FAIL basic_latency: got %0d, want %0d", lat, e.lat);
    else passed++;
    @(negedge clk);
    checks++;
    if ({done, busy, sum} !== {1'b1, 1'b0, e.res.sum})
      $display("[TB] FAIL basic_hold: done/busy/sum got %b/%b/%h, want 1/0/%h", done, busy, sum, e.res.sum);
    else passed++;
  endtask

  task automatic test_empty();
    exp_t    e;
    result_t obs;
    int      lat;
    bit      ok;
    clear_rom();
    launch_run();
    wait_done(1, lat, ok);
    checks++;
    if (!ok) $display("[TB] FAIL empty_timeout: done not seen within %0d cycles", LIMIT);
    else passed++;
    e = sb_q.pop_front();
    obs = {sum, count, overflow, addr};
    checks++;
    if (obs !== e.res) $display("[TB] FAIL empty_result: got %h, want %h", obs, e.res);
    else passed++;
    checks++;
    if (lat !== e.lat) $display("[TB] FAIL empty_latency: got %0d, want %0d", lat, e.lat);
    else passed++;
  endtask

  task automatic test_overflow();
    exp_t    e;
    result_t obs;
    int      lat;
    bit      ok;
    clear_rom();
    rom[0] = 32'hFFFF_FFFF;
    rom[1] = 32'd2;
    launch_run();
    wait_done(1, lat, ok);
    checks++;
    if (!ok) $display("[TB] FAIL ovf_timeout: done not seen within %0d cycles", LIMIT);
    else passed++;
    e = sb_q.pop_front();
    obs = {sum, count, overflow, addr};
    checks++;
    if (obs !== e.res) $display("[TB] FAIL ovf_result: got %h, want %h", obs, e.res);
    else passed++;
    // The second run must start with overflow cleared.
    clear_rom();
    rom[0] = 32'd1;
    launch_run();
    wait_done(1, lat, ok);
    checks++;
    if (!ok) $display("[TB] FAIL ovf_clear_timeout: done not seen within %0d cycles", LIMIT);
    else passed++;
    e = sb_q.pop_front();
    obs = {sum, count, overflow, addr};
    checks++;
    if (obs !== e.res) $display("[TB] FAIL ovf_clear_result: got %h, want %h", obs, e.res);
    else passed++;
  endtask

  task automatic test_full_rom();
    exp_t    e;
    result_t obs;
    int      lat;
    bit      ok;
    for (int i = 0; i < 256; i++) rom[i] = 32'd1;
    launch_run();
    wait_done(1, lat, ok);
    checks++;
    if (!ok) $display("[TB] FAIL full_timeout: done not seen within %0d cycles", LIMIT);
    else passed++;
    e = sb_q.pop_front();
    obs = {sum, count, overflow, addr};
    checks++;
    if (obs !== e.res) $display("[TB] FAIL full_result: got %h, want %h", obs, e.res);
    else passed++;
    checks++;
    if (lat !== e.lat) $display("[TB] FAIL full_latency: got %0d, want %0d", lat, e.lat);
    else passed++;
    @(negedge clk);
    checks++;
    if (addr !== 30'd255) $display("[TB] FAIL full_addr_hold: got %0d, want 255", addr);
    else passed++;
  endtask

  task automatic test_mid_reset();
    exp_t    e;
    result_t obs;
    int      lat;
    bit      ok;
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = 32'd1;
    launch_run();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    obs = {sum, count, overflow, addr};
    checks++;
    if (obs !== result_t'(0)) $display("[TB] FAIL midreset_regs: got %h, want 0", obs);
    else passed++;
    checks++;
    if ({busy, done} !== 2'b00 || dut.state !== IDLE)
      $display("[TB] FAIL midreset_state: busy/done/state got %b/%b/%0d, want 0/0/%0d", busy, done, dut.state, IDLE);
    else passed++;
    // The aborted run never produces a result, so drop its expectation.
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    launch_run();
    wait_done(1, lat, ok);
    checks++;
    if (!ok) $display("[TB] FAIL midreset_timeout: done not seen within %0d cycles", LIMIT);
    else passed++;
    e = sb_q.pop_front();
    obs = {sum, count, overflow, addr};
    checks++;
    if (obs !== e.res) $display("[TB] FAIL midreset_rerun: got %h, want %h", obs, e.res);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t    e;
    result_t obs;
    int      lat;
    bit      ok;
    clear_rom();
    rom[0] = 32'd3;
    rom[1] = 32'd4;
    launch_run();
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(3, lat, ok);
    checks++;
    if (!ok) $display("[TB] FAIL b2b_timeout: done not seen within %0d cycles", LIMIT);
    else passed++;
    e = sb_q.pop_front();
    obs = {sum, count, overflow, addr};
    checks++;
    if (obs !== e.res) $display("[TB] FAIL b2b_result: got %h, want %h", obs, e.res);
    else passed++;
    checks++;
    if (lat !== e.lat) $display("[TB] FAIL b2b_latency: got %0d, want %0d", lat, e.lat);
    else passed++;
    // Restart from DONE must clear the sum, not accumulate on top of it.
    launch_run();
    wait_done(1, lat, ok);
    checks++;
    if (!ok) $display("[TB] FAIL restart_timeout: done not seen within %0d cycles", LIMIT);
    else passed++;
    e = sb_q.pop_front();
    obs = {sum, count, overflow, addr};
    checks++;
    if (obs !== e.res) $display("[TB] FAIL restart_result: got %h, want %h", obs, e.res);
    else passed++;
    checks++;
    if (lat !== e.lat) $display("[TB] FAIL restart_latency: got %0d, want %0d", lat, e.lat);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_full_rom();
    test_mid_reset();
    test_back_to_back();
    checks++;
    if (sb_q.size() !== 0) $display("[TB] FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
